block_mem_responder: RTL and testbench

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/block_mem_responder_pkg.sv | 23 ++
 rtl/block_mem_responder_if.sv | 27 ++
 rtl/block_mem_responder_array.sv | 33 +++
 rtl/block_mem_responder.sv | 132 +++++++++++++
 tb/tb_block_mem_responder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/block_mem_responder_pkg.sv
// Shared cache/memory package: block geometry, responder defaults and the
// responder FSM state encoding used by the block memory model.
package block_mem_responder_pkg;

  // Geometry of the memory-side block bus
  localparam int BLOCK_BITS    = 128;
  localparam int MEM_ADDR_BITS = 28;

  // Latency counter is wide enough for the legal LATENCY range 1..15
  localparam int CNT_BITS = 4;

  // Responder defaults
  localparam int DEFAULT_LATENCY   = 5;
  localparam int DEFAULT_ADDR_BITS = 8;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/block_mem_responder_if.sv
// Block memory bus between a cache (master) and the memory responder (slave).
//   mem_read / mem_write : request strobes, held until mem_ready
//   mem_addr             : block address
//   mem_wdata            : write block, word 0 in bits [31:0]
//   mem_rdata            : read block, valid in the mem_ready cycle of a read
//   mem_ready            : one-cycle completion pulse
interface block_mem_responder_if;
  import block_mem_responder_pkg::*;

  logic                     mem_read;
  logic                     mem_write;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [BLOCK_BITS-1:0]    mem_wdata;
  logic [BLOCK_BITS-1:0]    mem_rdata;
  logic                     mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/block_mem_responder_array.sv
// Single-port block storage: synchronous write, asynchronous read, no reset
// (contents survive proc_reset by design).
//   clk   : clock
//   we    : write enable, commits wdata to addr on the rising edge
//   addr  : block index shared by read and write
//   wdata : block to write
//   rdata : block currently stored at addr
module block_mem_array
  import block_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [BLOCK_BITS-1:0] wdata,
  output logic [BLOCK_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [BLOCK_BITS-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/block_mem_responder.sv
// Fixed-latency block memory responder. A request seen in IDLE is latched
// (operation, index, write data); mem_ready pulses LATENCY cycles later in
// DONE, where a write commits and a read presents its block on mem_rdata.
//   clk        : clock
//   proc_reset : synchronous active-high reset (storage is not cleared)
//   bus        : block memory bus, slave side
module block_mem_responder
  import block_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic                        clk,
  input  logic                        proc_reset,
  block_mem_responder_if.slave        bus
);

  mem_state_e            state_r;
  mem_state_e            next_state_s;
  logic [CNT_BITS-1:0]   cnt_r;
  logic [CNT_BITS-1:0]   cnt_next_s;
  logic                  accept_s;
  logic                  op_write_r;
  logic [ADDR_BITS-1:0]  idx_r;
  logic [BLOCK_BITS-1:0] wdata_r;
  logic                  mem_ready_r;
  logic [BLOCK_BITS-1:0] mem_rdata_r;
  logic [ADDR_BITS-1:0]  arr_idx_s;
  logic [BLOCK_BITS-1:0] arr_rdata_s;
  logic                  arr_we_s;
  logic                  load_rdata_s;
  logic                  unused_addr_s;

  // Upper address bits alias away
  assign unused_addr_s = ^bus.mem_addr[MEM_ADDR_BITS-1:ADDR_BITS];

  // Next-state and counter logic
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    case (state_r)
      MEM_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          accept_s     = 1'b1;
          cnt_next_s   = CNT_BITS'(LATENCY - 1);
          next_state_s = (LATENCY == 1) ? MEM_DONE : MEM_BUSY;
        end else begin
          next_state_s = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          next_state_s = MEM_DONE;
        end else begin
          next_state_s = MEM_BUSY;
        end
      end
      MEM_DONE: begin
        next_state_s = MEM_IDLE;
      end
      default: begin
        next_state_s = MEM_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Storage port control: the index comes straight from the bus on the
  // accept cycle (needed when LATENCY=1) and from the latch afterwards
  always_comb begin
    arr_idx_s    = idx_r;
    load_rdata_s = 1'b0;
    if (state_r == MEM_IDLE) begin
      arr_idx_s = bus.mem_addr[ADDR_BITS-1:0];
    end else begin
      arr_idx_s = idx_r;
    end
    if (next_state_s == MEM_DONE) begin
      if (state_r == MEM_IDLE) begin
        load_rdata_s = ~bus.mem_write;
      end else begin
        load_rdata_s = ~op_write_r;
      end
    end else begin
      load_rdata_s = 1'b0;
    end
  end

  assign arr_we_s = (state_r == MEM_DONE) && op_write_r && !proc_reset;

  // FSM state, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_r     <= MEM_IDLE;
      cnt_r       <= 4'd0;
      op_write_r  <= 1'b0;
      idx_r       <= '0;
      wdata_r     <= '0;
      mem_ready_r <= 1'b0;
      mem_rdata_r <= '0;
    end else begin
      state_r     <= next_state_s;
      cnt_r       <= cnt_next_s;
      mem_ready_r <= (next_state_s == MEM_DONE);
      if (accept_s) begin
        // Write wins when both strobes are high
        op_write_r <= bus.mem_write;
        idx_r      <= bus.mem_addr[ADDR_BITS-1:0];
        wdata_r    <= bus.mem_wdata;
      end
      if (load_rdata_s) begin
        mem_rdata_r <= arr_rdata_s;
      end
    end
  end

  block_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .addr  (arr_idx_s),
    .wdata (wdata_r),
    .rdata (arr_rdata_s)
  );

  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_rdata_r;

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: one LATENCY=5 instance and one
// LATENCY=1 instance; read data is checked through an expected-data queue.
module tb_block_mem_responder;
  import block_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst5;
  logic rst1;

  always #5 clk = ~clk;

  block_mem_responder_if b5 ();
  block_mem_responder_if b1 ();

  block_mem_responder #(.ADDR_BITS(8), .LATENCY(5)) dut5 (
    .clk        (clk),
    .proc_reset (rst5),
    .bus        (b5)
  );

  block_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut1 (
    .clk        (clk),
    .proc_reset (rst1),
    .bus        (b1)
  );

  int checks = 0;
  int fails  = 0;

  logic [127:0] model [int];
  logic [127:0] exp_q [$];

  // One complete request on the LATENCY=5 instance, started #1 after an edge
  task automatic run_req5(input logic wr, input logic rd, input logic [27:0] addr,
                          input logic [127:0] wd, input string nm);
    int lat;
    logic [127:0] prev_rdata;
    logic [127:0] got;
    logic [127:0] exp;
    prev_rdata = b5.mem_rdata;
    b5.mem_write = wr;
    b5.mem_read  = rd;
    b5.mem_addr  = addr;
    b5.mem_wdata = wd;
    if (wr) model[int'(addr[7:0])] = wd;
    else    exp_q.push_back(model[int'(addr[7:0])]);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (b5.mem_ready === 1'b1) lat = k;
      end
    end
    b5.mem_write = 1'b0;
    b5.mem_read  = 1'b0;
    checks++;
    if (lat !== 5) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected 5", nm, lat);
    end
    got = b5.mem_rdata;
    if (!wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s_rdata: scoreboard empty", nm);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL %s_rdata: got %h expected %h", nm, got, exp);
        end
      end
    end else begin
      checks++;
      if (got !== prev_rdata) begin
        fails++;
        $display("FAIL %s_rdata_hold_on_write: got %h expected %h", nm, got, prev_rdata);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (b5.mem_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s_ready_width: got %b expected 0", nm, b5.mem_ready);
    end
    checks++;
    if (b5.mem_rdata !== got) begin
      fails++;
      $display("FAIL %s_rdata_hold: got %h expected %h", nm, b5.mem_rdata, got);
    end
  endtask

  task automatic test_reset();
    b5.mem_read = 1'b0; b5.mem_write = 1'b0; b5.mem_addr = '0; b5.mem_wdata = '0;
    b1.mem_read = 1'b0; b1.mem_write = 1'b0; b1.mem_addr = '0; b1.mem_wdata = '0;
    rst5 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b5.mem_ready !== 1'b0) begin fails++; $display("FAIL reset_ready5: got %b expected 0", b5.mem_ready); end
    checks++;
    if (b5.mem_rdata !== 128'd0) begin fails++; $display("FAIL reset_rdata5: got %h expected 0", b5.mem_rdata); end
    checks++;
    if (b1.mem_ready !== 1'b0) begin fails++; $display("FAIL reset_ready1: got %b expected 0", b1.mem_ready); end
    checks++;
    if (b1.mem_rdata !== 128'd0) begin fails++; $display("FAIL reset_rdata1: got %h expected 0", b1.mem_rdata); end
    rst5 = 1'b0;
    rst1 = 1'b0;
  endtask

  task automatic test_write_read();
    run_req5(1'b1, 1'b0, 28'h0000003, 128'h0123456789ABCDEF0123456789ABCDEF, "wr3");
    run_req5(1'b0, 1'b1, 28'h0000003, 128'd0, "rd3");
  endtask

  task automatic test_alias();
    run_req5(1'b1, 1'b0, 28'h0000105, {4{32'hAAAAAAAA}}, "wr105");
    run_req5(1'b0, 1'b1, 28'h0000005, 128'd0, "rd5_alias");
  endtask

  task automatic test_both_high();
    run_req5(1'b1, 1'b1, 28'h0000007, {4{32'h55555555}}, "both7");
    run_req5(1'b0, 1'b1, 28'h0000007, 128'd0, "rd7");
  endtask

  task automatic test_input_change();
    int first;
    int cnt;
    run_req5(1'b1, 1'b0, 28'h0000021, {4{32'h21210000}}, "wr21");
    b5.mem_write = 1'b1;
    b5.mem_addr  = 28'h0000020;
    b5.mem_wdata = {4{32'h20202020}};
    model[32'h20] = {4{32'h20202020}};
    first = 0;
    cnt   = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (b5.mem_ready === 1'b1) begin
        cnt++;
        if (first == 0) first = k;
      end
      if (k == 2) begin
        b5.mem_addr  = 28'h0000021;
        b5.mem_wdata = {4{32'hDEADBEEF}};
      end
      if (k == 3) b5.mem_write = 1'b0;
    end
    checks++;
    if (first !== 5) begin fails++; $display("FAIL chg_latency: got %0d expected 5", first); end
    checks++;
    if (cnt !== 1) begin fails++; $display("FAIL chg_ready_count: got %0d expected 1", cnt); end
    run_req5(1'b0, 1'b1, 28'h0000020, 128'd0, "chg_rd20");
    run_req5(1'b0, 1'b1, 28'h0000021, 128'd0, "chg_rd21");
  endtask

  task automatic test_reset_abort();
    int cnt;
    run_req5(1'b1, 1'b0, 28'h0000009, {4{32'h09090909}}, "wr9_old");
    b5.mem_write = 1'b1;
    b5.mem_addr  = 28'h0000009;
    b5.mem_wdata = {4{32'hFFFF0000}};
    cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (b5.mem_ready === 1'b1) cnt++;
      if (k == 3) begin
        rst5 = 1'b1;
        b5.mem_write = 1'b0;
      end
      if (k == 4) rst5 = 1'b0;
    end
    checks++;
    if (cnt !== 0) begin fails++; $display("FAIL abort_ready: got %0d pulses expected 0", cnt); end
    checks++;
    if (b5.mem_rdata !== 128'd0) begin fails++; $display("FAIL abort_rdata_clear: got %h expected 0", b5.mem_rdata); end
    run_req5(1'b0, 1'b1, 28'h0000009, 128'd0, "abort_rd9");
  endtask

  task automatic test_back_to_back();
    logic [7:0]   mask;
    logic [127:0] da;
    logic [127:0] exp;
    da   = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    mask = 8'd0;
    b1.mem_write = 1'b1;
    b1.mem_read  = 1'b0;
    b1.mem_addr  = 28'h0000010;
    b1.mem_wdata = da;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (b1.mem_ready === 1'b1) mask[k] = 1'b1;
      if (k == 1) begin
        b1.mem_write = 1'b0;
        b1.mem_read  = 1'b1;
        b1.mem_wdata = 128'd0;
        exp_q.push_back(da);
      end
      if (k == 3) begin
        b1.mem_read = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (b1.mem_rdata !== exp) begin
          fails++;
          $display("FAIL b2b_rdata: got %h expected %h", b1.mem_rdata, exp);
        end
      end
    end
    checks++;
    if (mask !== 8'b0000_1010) begin
      fails++;
      $display("FAIL b2b_ready_cycles: got %b expected 00001010", mask);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_both_high();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
